// File: rtl/fetch_buffer.sv
// In-order fetch buffer between the fetch unit and decode: issues one imem request per
// accepted PC, pairs responses with their PCs and drops stale responses after a redirect.
module fetch_buffer #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            fetch_stall,
  input  logic            flush,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_pc,
  output logic [XLEN-1:0] dec_instr
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = PW + 1;
  localparam logic [EW-1:0] DEPTH_X = EW'(DEPTH);

  logic [XLEN-1:0] r_slot_pc    [DEPTH];
  logic [XLEN-1:0] r_slot_instr [DEPTH];
  logic [PW-1:0]   r_alloc, r_fill, r_head, r_drop_cnt;

  logic [PW-1:0]   w_inflight, w_occ;
  logic [EW-1:0]   w_pending_total, w_drop_flush;
  logic            w_enq, w_deq, w_fill_en, w_drop_en, w_empty_req;

  assign w_inflight      = r_alloc - r_fill;
  assign w_occ           = r_alloc - r_head;
  assign w_pending_total = {1'b0, w_inflight} + {1'b0, r_drop_cnt};

  assign imem_req_valid = !reset && !flush && ({1'b0, w_occ} < DEPTH_X)
                          && (w_pending_total < DEPTH_X);
  assign imem_req_addr  = fetch_pc;
  assign fetch_stall    = !(imem_req_valid && imem_req_ready);

  // Head is ready only once its response has been registered: no combinational bypass.
  assign dec_valid = !reset && !flush && (r_head != r_fill);
  assign dec_pc    = reset ? '0 : r_slot_pc[r_head[AW-1:0]];
  assign dec_instr = reset ? '0 : r_slot_instr[r_head[AW-1:0]];

  assign w_enq       = imem_req_valid && imem_req_ready;
  assign w_deq       = dec_valid && dec_ready;
  assign w_drop_en   = !reset && !flush && imem_rsp_valid && (r_drop_cnt != '0);
  assign w_fill_en   = !reset && !flush && imem_rsp_valid && (r_drop_cnt == '0)
                       && (r_alloc != r_fill);
  assign w_empty_req = (w_pending_total == '0);

  // A response arriving in the flush cycle answers the oldest outstanding request.
  assign w_drop_flush = w_pending_total - {{(EW-1){1'b0}}, imem_rsp_valid && !w_empty_req};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_alloc    <= '0;
      r_fill     <= '0;
      r_head     <= '0;
      r_drop_cnt <= '0;
    end else if (flush) begin
      r_head     <= r_alloc;
      r_fill     <= r_alloc;
      r_drop_cnt <= PW'(w_drop_flush);
    end else begin
      if (w_enq)     r_alloc    <= r_alloc + 1'b1;
      if (w_fill_en) r_fill     <= r_fill + 1'b1;
      if (w_drop_en) r_drop_cnt <= r_drop_cnt - 1'b1;
      if (w_deq)     r_head     <= r_head + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_enq)     r_slot_pc[r_alloc[AW-1:0]]   <= fetch_pc;
    if (w_fill_en) r_slot_instr[r_fill[AW-1:0]] <= imem_rsp_data;
  end
endmodule

// File: tb/tb_fetch_buffer.sv
// Randomized bench for fetch_buffer: a fetch-unit and memory environment plus a queue-based
// reference of requested, ready and dropped instructions, checked every cycle.
module tb_fetch_buffer;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic            clock;
  logic            reset;
  logic [XLEN-1:0] fetch_pc;
  logic            fetch_stall;
  logic            flush;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            dec_valid;
  logic            dec_ready;
  logic [XLEN-1:0] dec_pc;
  logic [XLEN-1:0] dec_instr;

  fetch_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clock(clock), .reset(reset), .fetch_pc(fetch_pc), .fetch_stall(fetch_stall),
    .flush(flush), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_pc(dec_pc), .dec_instr(dec_instr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [XLEN-1:0] data;
    int              due;
  } mem_rsp_t;

  mem_rsp_t        mem_q[$];
  logic [XLEN-1:0] pend_q[$];
  logic [XLEN-1:0] rdy_q[$];
  int              n_drop;
  int              last_due;
  int              cyc;
  logic [XLEN-1:0] pc_nxt;
  logic [XLEN-1:0] flush_tgt;
  int              n_cmp;
  int              n_bad;
  int              p_dec, p_req, p_flush, lat_min, lat_max;

  function automatic logic [XLEN-1:0] memfn(input logic [XLEN-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string name, input logic [XLEN-1:0] got,
                       input logic [XLEN-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  task automatic drive_cycle(input logic rst);
    logic [XLEN-1:0] tmp;
    @(posedge clock);
    #1;
    cyc++;
    reset    = rst;
    fetch_pc = pc_nxt;
    flush    = !rst && ($urandom_range(99) < p_flush);
    tmp      = $urandom();
    flush_tgt = tmp & ~32'h3;
    dec_ready      = ($urandom_range(99) < p_dec);
    imem_req_ready = ($urandom_range(99) < p_req);
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_q[0].data;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom();
    end
  endtask

  task automatic phase(input int n, input int pd, input int pr, input int pf,
                       input int lmin, input int lmax);
    p_dec = pd; p_req = pr; p_flush = pf; lat_min = lmin; lat_max = lmax;
    for (int i = 0; i < n; i++) drive_cycle(1'b0);
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b1);
  endtask

  // Reference model: compare DUT outputs, then advance the model to the coming edge.
  always @(negedge clock) begin
    if (cyc > 0) begin
      logic exp_rv, exp_dv;
      int   tot, lat, due;
      exp_rv = !reset && !flush && ((rdy_q.size() + pend_q.size()) < DEPTH)
               && ((pend_q.size() + n_drop) < DEPTH);
      exp_dv = !reset && !flush && (rdy_q.size() > 0);
      check("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
      check("fetch_stall", {31'b0, fetch_stall}, {31'b0, !(exp_rv && imem_req_ready)});
      check("dec_valid", {31'b0, dec_valid}, {31'b0, exp_dv});
      if (exp_rv) check("req_addr", imem_req_addr, fetch_pc);
      if (exp_dv) begin
        check("dec_pc", dec_pc, rdy_q[0]);
        check("dec_instr", dec_instr, memfn(rdy_q[0]));
      end
      if (reset) begin
        check("rst_dec_pc", dec_pc, '0);
        check("rst_dec_instr", dec_instr, '0);
      end

      if (reset) begin
        mem_q.delete(); pend_q.delete(); rdy_q.delete();
        n_drop = 0; last_due = 0; pc_nxt = '0;
      end else begin
        if (imem_rsp_valid && mem_q.size() > 0) void'(mem_q.pop_front());
        if (imem_req_valid && imem_req_ready) begin
          lat = $urandom_range(lat_max, lat_min);
          due = (cyc + lat > last_due) ? cyc + lat : last_due;
          last_due = due;
          mem_q.push_back('{memfn(imem_req_addr), due});
        end
        if (flush) begin
          tot = pend_q.size() + n_drop;
          n_drop = (imem_rsp_valid && tot > 0) ? tot - 1 : tot;
          pend_q.delete();
          rdy_q.delete();
          pc_nxt = flush_tgt;
        end else begin
          if (exp_dv && dec_ready) void'(rdy_q.pop_front());
          if (imem_rsp_valid) begin
            if (n_drop > 0) n_drop--;
            else if (pend_q.size() > 0) rdy_q.push_back(pend_q.pop_front());
          end
          if (exp_rv && imem_req_ready) pend_q.push_back(fetch_pc);
          pc_nxt = fetch_stall ? fetch_pc : fetch_pc + 32'd4;
        end
      end
    end
  end

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0; n_drop = 0; last_due = 0;
    pc_nxt = '0; flush_tgt = '0;
    p_dec = 100; p_req = 100; p_flush = 0; lat_min = 1; lat_max = 1;
    reset = 1'b1; fetch_pc = '0; flush = 1'b0; imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; dec_ready = 1'b1;

    reset_cycles(3);
    phase(20, 100, 100, 0, 1, 1);   // free run, latency 1
    phase(12, 0, 100, 0, 1, 1);     // decode stalled until full
    phase(10, 100, 100, 0, 1, 1);   // drain and resume
    phase(20, 100, 60, 0, 1, 1);    // memory request back-pressure
    phase(60, 70, 100, 15, 3, 3);   // latency 3 with redirects
    phase(8, 0, 100, 0, 1, 1);      // fill, then reset mid-stream
    reset_cycles(2);
    phase(20, 100, 100, 0, 1, 1);
    phase(1500, 60, 70, 5, 1, 4);   // mixed random traffic
    phase(40, 100, 100, 0, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Sits directly downstream of the fetch unit and upstream of decode.
- Takes the fetch unit's current PC each cycle and issues it as an instruction-memory request.
- Holds returned instructions, each paired with its PC, in an in-order buffer of DEPTH entries and presents them to decode with a valid/ready handshake.
- Back-pressures the fetch unit through fetch_stall, and drops all buffered and in-flight instructions on a redirect flush.

Parameters:
DEPTH, 4, buffer entries and maximum outstanding memory requests (power of 2, >= 2)
XLEN, 32, PC and instruction width

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
fetch_pc  in  XLEN  current PC from fetch unit
fetch_stall  out  1  to fetch unit stall input; high holds the PC
flush  in  1  redirect; same cycle the fetch unit loads npc
imem_req_valid  out  1  request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  request address (= fetch_pc)
imem_rsp_valid  in  1  response valid; in order, latency >= 1 cycle
imem_rsp_data  in  XLEN  instruction word
dec_valid  out  1  head entry holds an instruction
dec_ready  in  1  decode accepts head
dec_pc  out  XLEN  PC of head entry
dec_instr  out  XLEN  instruction of head entry

Behaviour:
- Reset is synchronous and active-high, clocked on clock.
- Reset clears head/fill/alloc pointers, the drop counter and all valid state.
- While reset is high:
  - imem_req_valid=0, dec_valid=0, fetch_stall=1.
  - dec_pc and dec_instr read 0.
- Storage:
  - Circular array of DEPTH slots {pc, instr}.
  - Three pointers, each log2(DEPTH)+1 bits with a wrap bit: alloc (tail), fill, head.
  - Slots between head and fill are ready.
  - Slots between fill and alloc are awaiting a response.
- Request issue:
  - imem_req_valid = !flush && (alloc-head) < DEPTH && (alloc-fill)+drop_cnt < DEPTH.
  - imem_req_addr = fetch_pc.
  - On imem_req_valid && imem_req_ready, slot[alloc].pc <= fetch_pc and alloc increments.
- fetch_stall = !(imem_req_valid && imem_req_ready).
  - The PC advances only when its request is accepted, so no PC is skipped or duplicated.
- Response:
  - If drop_cnt>0, the response is discarded and drop_cnt decrements.
  - Otherwise slot[fill].instr <= imem_rsp_data and fill increments.
  - imem_rsp_valid with nothing outstanding is a protocol error and is ignored.
- Decode handshake:
  - dec_valid = (head != fill) && !flush.
  - dec_pc and dec_instr are driven from slot[head].
  - On dec_valid && dec_ready, head increments.
  - Outputs hold stable while dec_valid && !dec_ready.
- Flush (highest priority):
  - head, fill <= alloc.
  - drop_cnt <= drop_cnt + (alloc-fill) - imem_rsp_valid.
  - No request is issued and no dequeue occurs in the flush cycle.
  - The first request after a flush uses the redirected PC, one cycle later.
- Simultaneous events (no flush):
  - Enqueue, response and dequeue in the same cycle are all honoured.
  - A response filling the head slot is visible on dec_valid the next cycle, never combinationally (1-cycle buffer latency).
- Full condition:
  - Buffer full ((alloc-head)==DEPTH) forces imem_req_valid=0 and fetch_stall=1 until decode dequeues.
- Reset mid-operation:
  - All state is cleared; any pending responses after reset are not tracked.
  - Memory must also be reset.

Test Plan:
- Reset then free run (mem latency 1, dec_ready=1) with fetch_pc 0,4,8,... -> dec_valid first high 2 cycles after reset falls (request cycle + response cycle); dec_pc=0 then 4, 8 on consecutive cycles; dec_instr matches mem; fetch_stall=0 throughout.
- dec_ready=0 with DEPTH=4 -> exactly 4 requests accepted (PCs 0,4,8,C); fetch_stall=1 from the 5th cycle on; dec_pc held at 0; releasing dec_ready drains 0,4,8,C in order and issue resumes at 0x10.
- imem_req_ready low 3 cycles -> fetch_stall=1 for those 3 cycles, imem_req_addr held constant, no gap or duplicate in the dec_pc sequence.
- Mem latency 3, flush asserted with 2 requests in flight and 1 ready entry -> dec_valid=0 in the flush cycle and after; the 2 stale responses are discarded; the next dec_pc equals the redirect target (e.g. 0x100).
- Flush in the same cycle as a response and a dec_ready handshake -> no dequeue; that response is counted as dropped; drop_cnt = outstanding - 1; the buffer is empty next cycle.
- Reset asserted mid-stream with a full buffer -> next cycle dec_valid=0, imem_req_valid=0, fetch_stall=1; after release, issue restarts at PC 0 with the buffer empty.
